wb_memory_bridge: RTL
=====================

WB_MEMORY_BRIDGE -- requirements
Module: wb_memory_bridge

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1: idle cycles inserted before each memory access, range 0..15.
REQ-002 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-003 wb_clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 wb_rst_i  input  1  asynchronous active-high reset.
REQ-005 wb_adr_i  input  19  word address, byte address bits [19:1].
REQ-006 wb_dat_i  input  16  write data.
REQ-007 wb_dat_o  output  16  read data, registered.
REQ-008 wb_sel_i  input  2  byte lane selects, bit0 = low byte (even address).
REQ-009 wb_we_i  input  1  1 = write cycle.
REQ-010 wb_cyc_i, wb_stb_i  input  1 each  Wishbone classic cycle/strobe.
REQ-011 wb_ack_o  output  1  single-cycle acknowledge.
REQ-012 mem_addr  output  20  byte address to memory model.
REQ-013 mem_wr_data  output  16  write data to memory.
REQ-014 mem_rd_data  input  16  combinational read data from memory.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_byte_m  output  1  1 = byte access, 0 = word access.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, ACCESS and ACK.
REQ-018 IDLE: on wb_cyc_i & wb_stb_i & !wb_ack_o, SHALL latch adr, sel, we and dat_i, load the wait counter with WAIT_STATES, and go to WAIT, or go straight to ACCESS when WAIT_STATES = 0.
REQ-019 WAIT: SHALL decrement the counter each cycle and go to ACCESS on the cycle the counter reaches 0; if wb_cyc_i drops, SHALL return to IDLE with no memory access and no ack.
REQ-020 ACCESS: lasts exactly one cycle; mem_* driven from latched request; mem_we = latched we & (sel != 00); SHALL capture mem_rd_data into wb_dat_o at the end of the cycle; next state ACK unconditionally.
REQ-021 ACK: SHALL assert wb_ack_o = wb_cyc_i for exactly one cycle, then go to IDLE.
REQ-022 Latency from strobe sampled to wb_ack_o high SHALL be WAIT_STATES+2 cycles; back-to-back requests SHALL cost one IDLE cycle between acks.
REQ-023 sel=11 SHALL drive mem_addr={adr,0}, mem_byte_m=0, mem_wr_data=dat_i, and wb_dat_o=mem_rd_data.
REQ-024 sel=01 SHALL drive mem_addr={adr,0}, mem_byte_m=1, mem_wr_data={8'h00,dat_i[7:0]}, and wb_dat_o={8'h00,rd[7:0]}.
REQ-025 sel=10 SHALL drive mem_addr={adr,1}, mem_byte_m=1, mem_wr_data={8'h00,dat_i[15:8]}, and wb_dat_o={rd[7:0],8'h00}.
REQ-026 sel=00 SHALL perform no write, SHALL still ack on the normal schedule, and SHALL set wb_dat_o=0.
REQ-027 Outside ACCESS, mem_we SHALL be 0; mem_addr, mem_wr_data and mem_byte_m SHALL hold their last values.
REQ-028 Word access at adr=19'h7FFFF SHALL pass mem_addr=20'hFFFFE unchanged; the memory wraps the high byte to 0.
REQ-029 wb_ack_o SHALL never be asserted in two consecutive cycles.

Reset
REQ-030 wb_rst_i high SHALL force IDLE immediately, including mid-WAIT, mid-ACCESS and mid-ACK, with no completion or ack of the aborted cycle.
REQ-031 Reset values SHALL be: wb_ack_o=0, wb_dat_o=0, mem_we=0, mem_addr=0, mem_wr_data=0, mem_byte_m=0, and wait counter=0.

Structure
REQ-032 State encodings and sel codes (SEL_NONE, SEL_LO, SEL_HI, SEL_WORD) SHALL live in the shared memory-bus package/include.
REQ-033 Lane steering for REQ-023..026 SHALL be one combinational sub-module, wb_mem_lane; the FSM and counter SHALL stay in wb_memory_bridge.

Verification
REQ-034 WAIT_STATES=1, word write adr=19'h08000, sel=11, dat=16'hBEEF -> mem_we high for 1 cycle with mem_addr=20'h10000; ack 3 cycles after stb; memory bytes 0x10000=EF and 0x10001=BE.
REQ-035 Byte write sel=10, adr=19'h08000, dat=16'h5A00, then word read -> mem_addr=20'h10001, byte_m=1; read returns 16'h5AEF.
REQ-036 Byte read sel=01 of a location holding 8'h80 -> wb_dat_o=16'h0080 (sign extension stripped); sel=10 read of 8'h80 -> 16'h8000.
REQ-037 sel=00 write -> ack on schedule, mem_we never high, memory unchanged, wb_dat_o=0.
REQ-038 WAIT_STATES=3: drop cyc in WAIT -> no mem_we, no ack, FSM in IDLE next cycle; assert reset during ACCESS of a write -> ack never asserted, all outputs at reset values.
REQ-039 Two back-to-back word reads at WAIT_STATES=0 -> acks exactly 3 cycles apart, each single-cycle, with correct data.

Source files
------------

// File: rtl/wb_mem_pkg.sv
// Shared memory-bus definitions: FSM state encoding, byte-lane select codes
// and the latched Wishbone request record.
package wb_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;
  localparam logic [1:0] SEL_WORD = 2'b11;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic        we;
    logic [1:0]  sel;
    logic [18:0] adr;
    logic [15:0] dat;
  } req_t;

endpackage

// File: rtl/wb_mem_lane.sv
// Byte-lane steering between the 16-bit Wishbone side and the byte-addressed
// memory: address LSB, byte/word mode, write-data and read-data alignment.
module wb_mem_lane
  import wb_mem_pkg::*;
(
  input  logic [18:0] adr_i,
  input  logic [1:0]  sel_i,
  input  logic [15:0] wr_dat_i,
  input  logic [15:0] rd_dat_i,
  output logic [19:0] mem_addr_o,
  output logic        mem_byte_o,
  output logic [15:0] mem_wr_o,
  output logic [15:0] rd_dat_o
);

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    mem_addr_o = {adr_i, 1'b0};
    mem_byte_o = 1'b0;
    mem_wr_o   = wr_dat_i;
    rd_dat_o   = '0;
    case (sel_i)
      SEL_WORD: rd_dat_o = rd_dat_i;
      SEL_LO: begin
        mem_byte_o = 1'b1;
        mem_wr_o   = {8'h00, wr_dat_i[7:0]};
        rd_dat_o   = {8'h00, rd_dat_i[7:0]};
      end
      SEL_HI: begin
        mem_addr_o = {adr_i, 1'b1};
        mem_byte_o = 1'b1;
        mem_wr_o   = {8'h00, wr_dat_i[15:8]};
        rd_dat_o   = {rd_dat_i[7:0], 8'h00};
      end
      default: ; // no lanes selected: read data stays zero
    endcase
  end

endmodule

// File: rtl/wb_memory_bridge.sv
// Wishbone classic slave to byte-addressed memory bridge with a programmable
// number of wait states ahead of each one-cycle memory access.
module wb_memory_bridge
  import wb_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [18:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic [19:0] mem_addr,
  output logic [15:0] mem_wr_data,
  input  logic [15:0] mem_rd_data,
  output logic        mem_we,
  output logic        mem_byte_m
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic [19:0]      mem_addr_q;
  logic [15:0]      mem_wr_q;
  logic             mem_byte_q;
  logic [15:0]      dat_q;

  logic [19:0]      lane_addr;
  logic [15:0]      lane_wr;
  logic             lane_byte;
  logic [15:0]      lane_rd;

  // Fed from req_d so a zero-wait access is steered from the request being
  // latched; during ACCESS req_d equals req_q.
  wb_mem_lane u_lane (
    .adr_i      (req_d.adr),
    .sel_i      (req_d.sel),
    .wr_dat_i   (req_d.dat),
    .rd_dat_i   (mem_rd_data),
    .mem_addr_o (lane_addr),
    .mem_byte_o (lane_byte),
    .mem_wr_o   (lane_wr),
    .rd_dat_o   (lane_rd)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the request holding registers are reset too so
  // the memory-side outputs come up at zero.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      mem_addr_q <= '0;
      mem_wr_q   <= '0;
      mem_byte_q <= 1'b0;
      dat_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      if (state_d == ST_ACCESS) begin
        mem_addr_q <= lane_addr;
        mem_wr_q   <= lane_wr;
        mem_byte_q <= lane_byte;
      end
      if (state_q == ST_ACCESS) dat_q <= lane_rd;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i && !wb_ack_o) begin
          req_d   = '{we: wb_we_i, sel: wb_sel_i, adr: wb_adr_i, dat: wb_dat_i};
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (!wb_cyc_i) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_ACK;
      ST_ACK:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_ack_o = (state_q == ST_ACK) && wb_cyc_i;
    mem_we   = (state_q == ST_ACCESS) && req_q.we && (req_q.sel != SEL_NONE);
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_q;
  assign mem_byte_m  = mem_byte_q;
  assign wb_dat_o    = dat_q;

endmodule
